// File: rtl/datapath_xyz.sv
// -----------------------------------------------------------------------------
// datapath_xyz
//   Register-level datapath driven by per-cycle control words from an external
//   control unit. Three registers: X (operand input), Y (accumulator holding the
//   ULA result) and Z (display output), plus a carry flag that lets a
//   WIDTH+1-bit sum be halved exactly by a Y shift-right.
//
// Ports
//   clock    in   rising-edge clock, shared with the control unit
//   resetn   in   asynchronous active-low reset
//   data_in  in   operand loaded into X
//   tx/ty/tz in   register control codes (0 CLEAR, 1 LOAD, 2 HOLD, 3 SHR, else HOLD)
//   tula     in   ULA select (0 ADD, 1 SUB, 2 AND, 3 OR, else pass X)
//   x_out    out  X register
//   y_out    out  Y register
//   z_out    out  Z register (display value)
//   carry    out  carry/borrow captured by the last Y load
//   z_valid  out  high for the cycle following a Z load
// -----------------------------------------------------------------------------
module datapath_xyz #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       tx,
  input  logic [3:0]       ty,
  input  logic [3:0]       tz,
  input  logic [3:0]       tula,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             carry,
  output logic             z_valid
);

  localparam logic [3:0] REG_CLEAR = 4'd0;
  localparam logic [3:0] REG_LOAD  = 4'd1;
  localparam logic [3:0] REG_SHR   = 4'd3;

  localparam logic [3:0] ULA_ADD = 4'd0;
  localparam logic [3:0] ULA_SUB = 4'd1;
  localparam logic [3:0] ULA_AND = 4'd2;
  localparam logic [3:0] ULA_OR  = 4'd3;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             carry_q, carry_d;
  logic             z_valid_q, z_valid_d;

  logic [WIDTH-1:0] ula_res;
  logic             ula_carry;
  logic [WIDTH:0]   ula_sum;
  logic [WIDTH:0]   ula_diff;

  // ULA: a = Y, b = X. Both results are computed one bit wider so the top bit
  // is the carry (ADD) or the borrow (SUB, set exactly when a < b).
  always_comb begin
    ula_sum  = {1'b0, y_q} + {1'b0, x_q};
    ula_diff = {1'b0, y_q} - {1'b0, x_q};
    ula_res  = x_q;
    ula_carry = 1'b0;
    case (tula)
      ULA_ADD: begin
        ula_res   = ula_sum[WIDTH-1:0];
        ula_carry = ula_sum[WIDTH];
      end
      ULA_SUB: begin
        ula_res   = ula_diff[WIDTH-1:0];
        ula_carry = ula_diff[WIDTH];
      end
      ULA_AND: ula_res = y_q & x_q;
      ULA_OR:  ula_res = y_q | x_q;
      default: ula_res = x_q;
    endcase
  end

  // Next-state for every register is formed from pre-edge values only.
  always_comb begin
    x_d = x_q;
    case (tx)
      REG_CLEAR: x_d = '0;
      REG_LOAD:  x_d = data_in;
      REG_SHR:   x_d = {1'b0, x_q[WIDTH-1:1]};
      default:   x_d = x_q;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    carry_d = carry_q;
    case (ty)
      REG_CLEAR: begin
        y_d     = '0;
        carry_d = 1'b0;
      end
      REG_LOAD: begin
        y_d     = ula_res;
        carry_d = ula_carry;
      end
      REG_SHR: begin
        // The carry becomes the MSB so (carry:Y) / 2 is exact; it is consumed.
        y_d     = {carry_q, y_q[WIDTH-1:1]};
        carry_d = 1'b0;
      end
      default: begin
        y_d     = y_q;
        carry_d = carry_q;
      end
    endcase
  end

  always_comb begin
    z_d = z_q;
    case (tz)
      REG_CLEAR: z_d = '0;
      REG_LOAD:  z_d = y_q;
      REG_SHR:   z_d = {1'b0, z_q[WIDTH-1:1]};
      default:   z_d = z_q;
    endcase
    z_valid_d = (tz == REG_LOAD);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      carry_q   <= 1'b0;
      z_valid_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      carry_q   <= carry_d;
      z_valid_q <= z_valid_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign z_out   = z_q;
  assign carry   = carry_q;
  assign z_valid = z_valid_q;

endmodule

// File: tb/tb_datapath_xyz.sv
// -----------------------------------------------------------------------------
// tb_datapath_xyz
//   Directed scenarios for the average-of-two flow plus randomized control
//   words, all compared against an arithmetic reference model of the datapath.
// -----------------------------------------------------------------------------
module tb_datapath_xyz;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clock;
  logic             resetn;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       tx, ty, tz, tula;
  logic [WIDTH-1:0] x_out, y_out, z_out;
  logic             carry, z_valid;

  int tests_run;
  int tests_failed;

  // reference model state
  int mx, my, mz, mc, mv;

  datapath_xyz #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .data_in(data_in),
    .tx     (tx),
    .ty     (ty),
    .tz     (tz),
    .tula   (tula),
    .x_out  (x_out),
    .y_out  (y_out),
    .z_out  (z_out),
    .carry  (carry),
    .z_valid(z_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mz = 0; mc = 0; mv = 0;
  endfunction

  // Behavioural model: plain integer arithmetic on the pre-edge values.
  function automatic void model_step(input int cx, input int cy, input int cz,
                                     input int cu, input int din);
    int ox, oy, oz, oc, ur, uc;
    ox = mx; oy = my; oz = mz; oc = mc;
    uc = 0;
    case (cu)
      0: begin ur = (oy + ox) % MOD; uc = (oy + ox) / MOD; end
      1: begin ur = (oy - ox + MOD) % MOD; uc = (oy < ox) ? 1 : 0; end
      2: ur = oy & ox;
      3: ur = oy | ox;
      default: ur = ox;
    endcase
    case (cx)
      0: mx = 0;
      1: mx = din;
      3: mx = ox / 2;
      default: mx = ox;
    endcase
    case (cy)
      0: begin my = 0; mc = 0; end
      1: begin my = ur; mc = uc; end
      3: begin my = (oy + MOD * oc) / 2; mc = 0; end
      default: begin my = oy; mc = oc; end
    endcase
    case (cz)
      0: mz = 0;
      1: mz = oy;
      3: mz = oz / 2;
      default: mz = oz;
    endcase
    mv = (cz == 1) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check_value({tag, ".x"}, int'(x_out), mx);
    check_value({tag, ".y"}, int'(y_out), my);
    check_value({tag, ".z"}, int'(z_out), mz);
    check_value({tag, ".c"}, int'(carry), mc);
    check_value({tag, ".v"}, int'(z_valid), mv);
  endtask

  // Apply one control word, clock it in, then compare away from the edge.
  task automatic do_cycle(input string tag, input int cx, input int cy,
                          input int cz, input int cu, input int din);
    tx      = 4'(cx);
    ty      = 4'(cy);
    tz      = 4'(cz);
    tula    = 4'(cu);
    data_in = WIDTH'(din);
    @(posedge clock);
    #1;
    model_step(cx, cy, cz, cu, din);
    $display("[TB] %s tx=%0d ty=%0d tz=%0d tula=%0d din=%0d -> X=%0d Y=%0d Z=%0d c=%0d v=%0d",
             tag, cx, cy, cz, cu, din, x_out, y_out, z_out, carry, z_valid);
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge: asserts reset mid-cycle, checks the
  // outputs clear without a clock edge, and releases before the next edge.
  task automatic async_reset(input string tag);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    $display("[TB] %s async reset -> X=%0d Y=%0d Z=%0d c=%0d v=%0d",
             tag, x_out, y_out, z_out, carry, z_valid);
    check_all(tag);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn  = 1'b0;
    data_in = '0;
    tx = 4'd1; ty = 4'd1; tz = 4'd1; tula = 4'd0;
    model_reset();
    // reset is held across an edge with load codes present
    #12;
    check_all("reset");
    resetn = 1'b1;

    // 1: average of 5 and 3
    do_cycle("avg53.clearld", 1, 0, 0, 0, 5);
    do_cycle("avg53.addld",   1, 1, 2, 0, 3);
    do_cycle("avg53.add",     0, 1, 2, 0, 0);
    check_value("avg53.add.y_const", int'(y_out), 8);
    do_cycle("avg53.shiftr",  2, 3, 2, 0, 0);
    check_value("avg53.shr.y_const", int'(y_out), 4);
    do_cycle("avg53.display", 2, 0, 1, 0, 0);
    check_value("avg53.z_const", int'(z_out), 4);
    do_cycle("avg53.idle",    2, 2, 2, 0, 0);
    check_value("avg53.v_drop", int'(z_valid), 0);

    // 2: overflow average of 12 and 9
    do_cycle("avg129.clearld", 1, 0, 0, 0, 12);
    do_cycle("avg129.addld",   1, 1, 2, 0, 9);
    do_cycle("avg129.add",     0, 1, 2, 0, 0);
    check_value("avg129.add.y_const", int'(y_out), 5);
    check_value("avg129.add.c_const", int'(carry), 1);
    do_cycle("avg129.shiftr",  2, 3, 2, 0, 0);
    check_value("avg129.shr.y_const", int'(y_out), 10);
    check_value("avg129.shr.c_const", int'(carry), 0);
    do_cycle("avg129.display", 2, 0, 1, 0, 0);
    check_value("avg129.z_const", int'(z_out), 10);

    // 3: subtraction with and without borrow
    do_cycle("sub.setx2",  1, 0, 2, 0, 2);
    do_cycle("sub.sety2",  1, 1, 2, 4, 7);
    do_cycle("sub.2m7",    2, 1, 2, 1, 0);
    check_value("sub.2m7.y_const", int'(y_out), 11);
    check_value("sub.2m7.c_const", int'(carry), 1);
    do_cycle("sub.setx9",  1, 0, 2, 0, 9);
    do_cycle("sub.sety9",  1, 1, 2, 4, 4);
    do_cycle("sub.9m4",    2, 1, 2, 1, 0);
    check_value("sub.9m4.y_const", int'(y_out), 5);
    check_value("sub.9m4.c_const", int'(carry), 0);

    // 4: illegal codes hold everything (X=6, Y=3, Z=1 beforehand)
    do_cycle("ill.a", 1, 0, 0, 0, 1);
    do_cycle("ill.b", 1, 1, 2, 4, 3);
    do_cycle("ill.c", 1, 1, 1, 4, 6);
    do_cycle("ill.h", 2, 2, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      do_cycle($sformatf("ill.hold%0d", i), 9, 9, 9, 12, 15);
      check_value("ill.x_const", int'(x_out), 6);
      check_value("ill.y_const", int'(y_out), 3);
      check_value("ill.z_const", int'(z_out), 1);
    end

    // 5: asynchronous reset mid-sequence, then DISPLAY
    do_cycle("rst.clearld", 1, 0, 0, 0, 5);
    do_cycle("rst.addld",   1, 1, 2, 0, 3);
    do_cycle("rst.add",     0, 1, 2, 0, 0);
    async_reset("rst.mid");
    check_value("rst.y_const", int'(y_out), 0);
    do_cycle("rst.display", 2, 0, 1, 0, 0);
    check_value("rst.z_const", int'(z_out), 0);
    check_value("rst.v_const", int'(z_valid), 1);
    do_cycle("rst.idle",    2, 2, 2, 0, 0);

    // 6: back-to-back DISPLAY with Y=7
    do_cycle("dd.clearld", 1, 0, 0, 0, 7);
    do_cycle("dd.sety",    2, 1, 2, 4, 0);
    do_cycle("dd.disp1",   2, 0, 1, 0, 0);
    check_value("dd.disp1.z_const", int'(z_out), 7);
    do_cycle("dd.disp2",   2, 0, 1, 0, 0);
    check_value("dd.disp2.z_const", int'(z_out), 0);
    check_value("dd.disp2.v_const", int'(z_valid), 1);

    // randomized control words with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      int cx, cy, cz, cu;
      cx = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      cy = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      cz = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      cu = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      do_cycle($sformatf("rnd%0d", i), cx, cy, cz, cu, int'($urandom_range(0, MOD - 1)));
      if ($urandom_range(0, 39) == 0) async_reset($sformatf("rnd%0d.rst", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/datapath_xyz.md
Name: datapath_xyz

Overview:
- Register-level datapath that executes the 4-bit control words (tx, ty, tz, tula) produced by the control unit each clock.
- Holds three registers: X (operand input), Y (accumulator / ULA result) and Z (display output), plus an ULA and a carry flag.
- Implements the CLEARLD / ADDLD / ADD / SHIFTR / DISPLAY average-of-two flow. Z drives the display decoder.

Parameters:
WIDTH, 4, data width of X, Y, Z, data_in and the ULA.

Ports:
clock  input  1  rising-edge clock, shared with the control unit
resetn  input  1  asynchronous active-low reset
data_in  input  WIDTH  operand loaded into X
tx  input  4  X register control code
ty  input  4  Y register control code
tz  input  4  Z register control code
tula  input  4  ULA operation select
x_out  output  WIDTH  X register
y_out  output  WIDTH  Y register
z_out  output  WIDTH  Z register (display value)
carry  output  1  carry/borrow flag from the last Y load
z_valid  output  1  one-cycle pulse, high the cycle after Z loads

Behaviour:
- Reset (resetn=0, asynchronous): X=0, Y=0, Z=0, carry=0, z_valid=0. All hold while resetn=0. The first update happens on the first rising edge after release.
- Register codes, common to tx, ty and tz:
  - 0 = CLEAR (0)
  - 1 = LOAD
  - 2 = HOLD
  - 3 = SHIFT RIGHT
  - 4..15 = HOLD (no error)
- Load sources:
  - X loads data_in.
  - Y loads the ULA result.
  - Z loads Y (pre-edge value).
- Shift right:
  - X and Z: logical shift, MSB filled with 0.
  - Y: MSB filled with the carry flag, so a WIDTH+1-bit sum is halved exactly. The carry flag clears to 0 in the same cycle.
- Carry on CLEAR: if ty=CLEAR, carry clears to 0.
- Simultaneous updates: all registers update on the same edge from pre-edge values. Example: tx=CLEAR with ty=LOAD means Y uses the old X.
- ULA: combinational, operands a=Y, b=X, result truncated to WIDTH.
  - 0 ADD: a+b, carry = bit WIDTH of the sum
  - 1 SUB: a-b, carry = borrow (1 if a<b)
  - 2 AND: carry=0
  - 3 OR: carry=0
  - 4..15: pass b, carry=0
- Carry update: carry changes only when ty=LOAD (takes the ULA carry), ty=SHIFT (clears) or ty=CLEAR (clears). Otherwise it holds.
- z_valid: registered, equals 1 exactly in the cycle after an edge where tz=LOAD, otherwise 0. Back-to-back loads give back-to-back pulses.
- Latency: one edge from control word to register value. No internal state machine; sequencing is owned by the control unit.
- Reset mid-sequence: all state returns to reset values immediately; a pending z_valid is dropped.
- Overflow wrap: ADD wraps modulo 2^WIDTH; the lost bit is preserved only in carry.

Test Plan (WIDTH=4):
1. Average sequence 5,3:
   - CLEARLD(1,0,0,0) with data_in=5 -> X=5, Y=0, Z=0.
   - ADDLD(1,1,2,0) with data_in=3 -> X=3, Y=5.
   - ADD(0,1,2,0) -> X=0, Y=8, carry=0.
   - SHIFTR(2,3,2,0) -> Y=4.
   - DISPLAY(2,0,1,0) -> Z=4, Y=0; z_valid=1 for exactly the next cycle.
2. Overflow average 12,9 through the same sequence:
   - After ADD: Y=5, carry=1.
   - After SHIFTR: Y=10, carry=0.
   - After DISPLAY: Z=10.
3. SUB: Y=2, X=7, ty=1, tula=1 -> Y=11 (0xB), carry=1. Then Y=9, X=4, SUB -> Y=5, carry=0.
4. Illegal codes: tx=ty=tz=9, tula=12 with X=6, Y=3, Z=1 -> all registers, carry and z_valid unchanged for 5 cycles.
5. Asynchronous reset:
   - Drop resetn mid-cycle after the ADD step -> X=Y=Z=0, carry=0 immediately, without waiting for a clock edge.
   - Release, then DISPLAY -> Z=0, z_valid pulses once.
6. Consecutive DISPLAY for two cycles with Y=7 before -> Z=7 then Z=0 (the second load takes the cleared Y); z_valid high for two consecutive cycles.
